// File: rtl/parity_block_receiver.sv
// parity_block_receiver
// One-entry pipeline stage on the receive side of an even-parity link.
// It checks each accepted block {code, data} and forwards the data with a
// per-beat error flag. It also keeps error statistics: a sticky flag, a
// saturating counter, and a capture of the first failing block.
module parity_block_receiver #(
  parameter int DATA_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [DATA_WIDTH:0]      upstream_block,
  input  logic                     upstream_valid,
  output logic                     upstream_ready,
  output logic [DATA_WIDTH-1:0]    downstream_data,
  output logic                     downstream_error,
  output logic                     downstream_valid,
  input  logic                     downstream_ready,
  input  logic                     clear_errors,
  output logic                     error_sticky,
  output logic [COUNTER_WIDTH-1:0] error_count,
  output logic [DATA_WIDTH:0]      first_error_block,
  output logic                     first_error_valid
);

  localparam int BLOCK_WIDTH = DATA_WIDTH + 1;

  // An even-parity block XORs to zero, so any odd-weight corruption shows up as 1.
  function automatic logic block_parity_error(input logic [BLOCK_WIDTH-1:0] blk);
    return ^blk;
  endfunction

  logic                     data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     error_q, error_d;
  logic                     sticky_q, sticky_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [BLOCK_WIDTH-1:0]   first_blk_q, first_blk_d;
  logic                     first_vld_q, first_vld_d;

  logic                     accept_s;
  logic                     deliver_s;
  logic                     blk_err_s;
  logic                     sticky_base_s;
  logic [COUNTER_WIDTH-1:0] count_base_s;
  logic [BLOCK_WIDTH-1:0]   first_blk_base_s;
  logic                     first_vld_base_s;

  // The stage can take a new block whenever it is empty or its current block leaves this cycle.
  assign upstream_ready = !data_valid_q || downstream_ready;
  assign accept_s       = upstream_valid && upstream_ready;
  assign deliver_s      = data_valid_q && downstream_ready;
  assign blk_err_s      = block_parity_error(upstream_block);

  // Pipeline next state: accept overrides deliver, and a stall holds the entry.
  always_comb begin
    data_d       = data_q;
    error_d      = error_q;
    data_valid_d = data_valid_q;
    if (accept_s) begin
      data_d       = upstream_block[DATA_WIDTH-1:0];
      error_d      = blk_err_s;
      data_valid_d = 1'b1;
    end else if (deliver_s) begin
      data_valid_d = 1'b0;
    end else begin
      data_valid_d = data_valid_q;
    end
  end

  // Statistics next state: apply the clear first, so an erroneous accept in the same cycle wins.
  always_comb begin
    sticky_base_s    = sticky_q;
    count_base_s     = count_q;
    first_blk_base_s = first_blk_q;
    first_vld_base_s = first_vld_q;
    if (clear_errors) begin
      sticky_base_s    = 1'b0;
      count_base_s     = {COUNTER_WIDTH{1'b0}};
      first_blk_base_s = {BLOCK_WIDTH{1'b0}};
      first_vld_base_s = 1'b0;
    end else begin
      sticky_base_s    = sticky_q;
      count_base_s     = count_q;
      first_blk_base_s = first_blk_q;
      first_vld_base_s = first_vld_q;
    end

    sticky_d    = sticky_base_s;
    count_d     = count_base_s;
    first_blk_d = first_blk_base_s;
    first_vld_d = first_vld_base_s;
    if (accept_s && blk_err_s) begin
      sticky_d = 1'b1;
      if (count_base_s != {COUNTER_WIDTH{1'b1}}) begin
        count_d = count_base_s + COUNTER_WIDTH'(1);
      end else begin
        count_d = count_base_s;
      end
      if (!first_vld_base_s) begin
        first_blk_d = upstream_block;
        first_vld_d = 1'b1;
      end else begin
        first_blk_d = first_blk_base_s;
        first_vld_d = first_vld_base_s;
      end
    end else begin
      sticky_d    = sticky_base_s;
      count_d     = count_base_s;
      first_blk_d = first_blk_base_s;
      first_vld_d = first_vld_base_s;
    end
  end

  // State registers; reset discards any pending entry and all statistics.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_valid_q <= 1'b0;
      data_q       <= {DATA_WIDTH{1'b0}};
      error_q      <= 1'b0;
      sticky_q     <= 1'b0;
      count_q      <= {COUNTER_WIDTH{1'b0}};
      first_blk_q  <= {BLOCK_WIDTH{1'b0}};
      first_vld_q  <= 1'b0;
    end else begin
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      error_q      <= error_d;
      sticky_q     <= sticky_d;
      count_q      <= count_d;
      first_blk_q  <= first_blk_d;
      first_vld_q  <= first_vld_d;
    end
  end

  assign downstream_data   = data_q;
  assign downstream_error  = error_q;
  assign downstream_valid  = data_valid_q;
  assign error_sticky      = sticky_q;
  assign error_count       = count_q;
  assign first_error_block = first_blk_q;
  assign first_error_valid = first_vld_q;

endmodule
